// File: rtl/mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_pkg : size encodings, FSM state type and defaults for MEM stage    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package mem_pkg;
  typedef logic [1:0] size_t;
  localparam size_t SIZE_BYTE = 2'b00;
  localparam size_t SIZE_HALF = 2'b01;
  localparam size_t SIZE_WORD = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;
endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_unit_if : EX/MEM operands and MEM stage results             |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int NBits = 32
);
  logic             MemRead;
  logic             MemWrite;
  size_t            MemSize;
  logic             MemUnsigned;
  logic             Zero;
  logic             BranchEquals;
  logic             BranchNotEquals;
  logic             JumpControl;
  logic [NBits-1:0] ALUResult;
  logic [NBits-1:0] WriteData;
  logic [NBits-1:0] PC_4;
  logic [NBits-1:0] BranchAddress;
  logic [NBits-1:0] JumpAddress;
  logic             BranchControl;
  logic [NBits-1:0] NewPC;
  logic [NBits-1:0] DataAddress;
  logic [NBits-1:0] MemoryData;
  logic             MemoryDataValid;
  logic             Stall;
  logic             MemFault;

  modport master (
    output MemRead, MemWrite, MemSize, MemUnsigned, Zero, BranchEquals,
           BranchNotEquals, JumpControl, ALUResult, WriteData, PC_4,
           BranchAddress, JumpAddress,
    input  BranchControl, NewPC, DataAddress, MemoryData, MemoryDataValid,
           Stall, MemFault
  );

  modport slave (
    input  MemRead, MemWrite, MemSize, MemUnsigned, Zero, BranchEquals,
           BranchNotEquals, JumpControl, ALUResult, WriteData, PC_4,
           BranchAddress, JumpAddress,
    output BranchControl, NewPC, DataAddress, MemoryData, MemoryDataValid,
           Stall, MemFault
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | byte_lane_ram : word-wide data RAM with per-byte write enables         |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module byte_lane_ram #(
  parameter int MEMORY_DEPTH = 512,
  parameter int ADDR_W       = 9
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [3:0]        we_i,
  input  wire logic [31:0]       wdata_i,
  input  wire logic              re_i,
  output logic      [31:0]       rdata_o
);
  logic [31:0] mem_q [MEMORY_DEPTH];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_unit : MEM stage with sized loads/stores, latency, faults   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          NBits        = 32,
  parameter int          MEMORY_DEPTH = 512,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
  parameter int          MEM_LATENCY  = 2
) (
  input wire logic       clk,
  input wire logic       reset,
  mem_access_unit_if.slave bus
);
  localparam int ADDR_W = $clog2(MEMORY_DEPTH);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       lane_q;
  size_t            size_q;
  logic             uns_q;
  logic             valid_q;
  logic             fault_q;
  logic [NBits-1:0] data_addr;
  logic [NBits-3:0] word_idx;
  logic [1:0]       lane;
  logic             req, fault_cond, accept, commit;
  logic [3:0]       be, ram_we;
  logic [31:0]      ram_wdata, ram_rdata, load_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             taken;

  assign taken             = (bus.BranchEquals & bus.Zero) | (bus.BranchNotEquals & ~bus.Zero);
  assign bus.BranchControl = bus.JumpControl | taken;
  assign bus.NewPC         = bus.JumpControl ? bus.JumpAddress
                           : (taken ? bus.BranchAddress : bus.PC_4);

  assign data_addr       = bus.ALUResult - BASE_ADDRESS;
  assign bus.DataAddress = data_addr;
  assign word_idx        = data_addr[NBits-1:2];
  assign lane            = data_addr[1:0];

  assign req        = bus.MemRead | bus.MemWrite;
  assign fault_cond = (bus.MemRead & bus.MemWrite)
                    | (bus.MemSize == 2'b11)
                    | ((bus.MemSize == SIZE_HALF) & lane[0])
                    | ((bus.MemSize == SIZE_WORD) & (lane != 2'b00))
                    | ({2'b00, word_idx} >= 32'(MEMORY_DEPTH));
  assign accept     = (state_q == ST_IDLE) & req & ~fault_cond;
  // A single-cycle latency commits straight out of IDLE.
  assign commit     = ((state_q == ST_ACCESS) & (cnt_q == 4'd1))
                    | ((MEM_LATENCY == 1) & accept);
  assign bus.Stall  = accept | (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (MEM_LATENCY == 1) ? ST_DONE : ST_ACCESS;
          cnt_d   = 4'(MEM_LATENCY - 1);
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    be        = 4'b1111;
    ram_wdata = bus.WriteData;
    case (bus.MemSize)
      SIZE_BYTE: begin
        be        = 4'b0001 << lane;
        ram_wdata = {4{bus.WriteData[7:0]}};
      end
      SIZE_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{bus.WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Gating with reset keeps an abort on the commit edge from landing a write.
  assign ram_we = (commit & bus.MemWrite & ~reset) ? be : 4'b0000;

  byte_lane_ram #(
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .addr_i (word_idx[ADDR_W-1:0]),
    .we_i   (ram_we),
    .wdata_i(ram_wdata),
    .re_i   (commit & bus.MemRead),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= commit;
      fault_q <= (state_q == ST_IDLE) & req & fault_cond;
      if (commit & bus.MemRead) begin
        lane_q <= lane;
        size_q <= bus.MemSize;
        uns_q  <= bus.MemUnsigned;
      end
    end
  end

  assign byte_sel = ram_rdata[8*lane_q +: 8];
  assign half_sel = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    load_data = ram_rdata;
    case (size_q)
      SIZE_BYTE: load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  assign bus.MemoryData      = load_data;
  assign bus.MemoryDataValid = valid_q;
  assign bus.MemFault        = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_access_unit : directed + random checks against a byte model     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_pkg::*;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2, rst4;
  int   sel;
  int   checks = 0;
  int   errors = 0;

  mem_access_unit_if #(.NBits(32)) bus2 ();
  mem_access_unit_if #(.NBits(32)) bus4 ();

  mem_access_unit #(.NBits(32), .MEMORY_DEPTH(512), .BASE_ADDRESS(BASE), .MEM_LATENCY(2))
    u_dut2 (.clk(clk), .reset(rst2), .bus(bus2));
  mem_access_unit #(.NBits(32), .MEMORY_DEPTH(512), .BASE_ADDRESS(BASE), .MEM_LATENCY(4))
    u_dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  logic        o_stall, o_valid, o_fault;
  logic [31:0] o_data, o_daddr;
  assign o_stall = (sel == 4) ? bus4.Stall           : bus2.Stall;
  assign o_valid = (sel == 4) ? bus4.MemoryDataValid : bus2.MemoryDataValid;
  assign o_fault = (sel == 4) ? bus4.MemFault        : bus2.MemFault;
  assign o_data  = (sel == 4) ? bus4.MemoryData      : bus2.MemoryData;
  assign o_daddr = (sel == 4) ? bus4.DataAddress     : bus2.DataAddress;

  // Byte-addressed memory images (little-endian), one per DUT.
  logic [7:0]  mm [2][2048];
  logic [31:0] last_load [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_fault(input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic [31:0] alu);
    logic [31:0] off;
    off = alu - BASE;
    if (!(rd || wr)) return 1'b0;
    return (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) ||
           (sz == 2'd2 && off % 4 != 0) || (off / 4 >= 512);
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] off);
    logic [31:0] v;
    int nb;
    nb = nbytes(sz);
    v  = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(mm[k][int'(off) + i]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] alu, input logic [31:0] wd);
    if (sel == 4) begin
      bus4.MemRead = rd; bus4.MemWrite = wr; bus4.MemSize = sz;
      bus4.MemUnsigned = uns; bus4.ALUResult = alu; bus4.WriteData = wd;
    end else begin
      bus2.MemRead = rd; bus2.MemWrite = wr; bus2.MemSize = sz;
      bus2.MemUnsigned = uns; bus2.ALUResult = alu; bus2.WriteData = wd;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, BASE, 32'h0);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] alu, input logic [31:0] wd, input string tag);
    int          k, lat;
    logic [31:0] off, exp;
    k   = (sel == 4) ? 1 : 0;
    lat = (sel == 4) ? 4 : 2;
    off = alu - BASE;
    drive(rd, wr, sz, uns, alu, wd);
    if (model_fault(rd, wr, sz, alu)) begin
      @(negedge clk);
      chk({tag, ".daddr"}, o_daddr, off);
      chk({tag, ".stall"}, 32'(o_stall), 32'd0);
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk({tag, ".fault"}, 32'(o_fault), 32'd1);
      chk({tag, ".stall_f"}, 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, ".fault_end"}, 32'(o_fault), 32'd0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        if (c == 0) chk({tag, ".daddr"}, o_daddr, off);
        chk({tag, ".stall"}, 32'(o_stall), 32'd1);
        chk({tag, ".valid_early"}, 32'(o_valid), 32'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk({tag, ".stall_done"}, 32'(o_stall), 32'd0);
      chk({tag, ".valid"}, 32'(o_valid), 32'd1);
      if (rd) begin
        exp = model_load(k, sz, uns, off);
        last_load[k] = exp;
      end else begin
        for (int i = 0; i < nbytes(sz); i++) mm[k][int'(off) + i] = wd[8*i +: 8];
      end
      chk({tag, ".data"}, o_data, last_load[k]);
      @(posedge clk); #1 idle();
    end
  endtask

  task automatic branch_chk(input logic z, input logic beq, input logic bne, input logic j);
    logic [31:0] pc4, ba, ja, exp_pc;
    logic        exp_bc;
    pc4 = $urandom; ba = $urandom; ja = $urandom;
    bus2.Zero = z; bus2.BranchEquals = beq; bus2.BranchNotEquals = bne; bus2.JumpControl = j;
    bus2.PC_4 = pc4; bus2.BranchAddress = ba; bus2.JumpAddress = ja;
    #1;
    if (j)                            begin exp_pc = ja;  exp_bc = 1'b1; end
    else if ((beq && z) || (bne && !z)) begin exp_pc = ba;  exp_bc = 1'b1; end
    else                              begin exp_pc = pc4; exp_bc = 1'b0; end
    chk($sformatf("br%0d%0d%0d%0d.pc", z, beq, bne, j), bus2.NewPC, exp_pc);
    chk($sformatf("br%0d%0d%0d%0d.bc", z, beq, bne, j), 32'(bus2.BranchControl), 32'(exp_bc));
  endtask

  task automatic reset_abort(input int rcyc, input logic [31:0] alu, input logic [31:0] wd,
                             input string tag);
    drive(1'b0, 1'b1, SIZE_WORD, 1'b0, alu, wd);
    for (int c = 0; c < rcyc; c++) begin
      @(negedge clk);
      chk({tag, ".stall"}, 32'(o_stall), 32'd1);
      @(posedge clk); #1;
    end
    rst4 = 1'b1;
    idle();
    @(posedge clk); #1 rst4 = 1'b0;
    @(negedge clk);
    chk({tag, ".rst_stall"}, 32'(o_stall), 32'd0);
    chk({tag, ".rst_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".rst_fault"}, 32'(o_fault), 32'd0);
    chk({tag, ".rst_data"}, o_data, 32'd0);
    last_load[1] = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] off;
    int          r;
    sel = 2; idle();
    sel = 4; idle();
    bus2.Zero = 0; bus2.BranchEquals = 0; bus2.BranchNotEquals = 0; bus2.JumpControl = 0;
    bus2.PC_4 = 0; bus2.BranchAddress = 0; bus2.JumpAddress = 0;
    bus4.Zero = 0; bus4.BranchEquals = 0; bus4.BranchNotEquals = 0; bus4.JumpControl = 0;
    bus4.PC_4 = 0; bus4.BranchAddress = 0; bus4.JumpAddress = 0;
    last_load[0] = 32'h0; last_load[1] = 32'h0;
    rst2 = 1'b1; rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("reset.stall2", 32'(bus2.Stall), 32'd0);
    chk("reset.valid2", 32'(bus2.MemoryDataValid), 32'd0);
    chk("reset.fault2", 32'(bus2.MemFault), 32'd0);
    chk("reset.data2", bus2.MemoryData, 32'd0);
    chk("reset.stall4", 32'(bus4.Stall), 32'd0);
    chk("reset.data4", bus4.MemoryData, 32'd0);
    @(posedge clk); #1;

    sel = 2;
    access(0, 1, SIZE_WORD, 0, BASE + 32'h8, 32'hDEAD_BEEF, "st_word");
    access(1, 0, SIZE_WORD, 0, BASE + 32'h8, 32'h0, "ld_word");
    chk("ld_word.value", o_data, 32'hDEAD_BEEF);
    access(1, 0, SIZE_BYTE, 0, BASE + 32'hB, 32'h0, "ld_byte_s");
    chk("ld_byte_s.value", o_data, 32'hFFFF_FFDE);
    access(1, 0, SIZE_BYTE, 1, BASE + 32'hB, 32'h0, "ld_byte_u");
    chk("ld_byte_u.value", o_data, 32'h0000_00DE);
    access(1, 0, SIZE_HALF, 0, BASE + 32'h8, 32'h0, "ld_half_s");
    chk("ld_half_s.value", o_data, 32'hFFFF_BEEF);
    access(0, 1, SIZE_BYTE, 0, BASE + 32'h9, 32'hAAAA_AA55, "st_byte");
    access(1, 0, SIZE_WORD, 0, BASE + 32'h8, 32'h0, "ld_partial");
    chk("ld_partial.value", o_data, 32'hDEAD_55EF);

    access(0, 1, SIZE_WORD, 0, BASE + 32'h2, 32'h1111_1111, "flt_word");
    access(0, 1, SIZE_HALF, 0, BASE + 32'h1, 32'h2222_2222, "flt_half");
    access(0, 1, SIZE_WORD, 0, BASE + 32'd2048, 32'h3333_3333, "flt_range");
    access(1, 1, SIZE_WORD, 0, BASE + 32'h8, 32'h4444_4444, "flt_rdwr");
    access(0, 1, 2'b11, 0, BASE + 32'h8, 32'h5555_5555, "flt_size");
    access(1, 0, SIZE_WORD, 0, BASE + 32'h8, 32'h0, "ld_after_flt");
    chk("ld_after_flt.value", o_data, 32'hDEAD_55EF);

    for (int w = 0; w < 16; w++)
      access(0, 1, SIZE_WORD, 0, BASE + 32'h40 + 32'(4 * w), $urandom, "pre");
    for (int n = 0; n < 40; n++) begin
      r   = $urandom_range(0, 9);
      sz  = 2'($urandom_range(0, 3));
      off = 32'h40 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0 && sz != 2'd3) off = off & ~32'(nbytes(sz) - 1);
      if ($urandom_range(0, 7) == 0) off = off + 32'd2048;
      if (r == 0)     access(1, 1, sz, 1'($urandom), BASE + off, $urandom, "rnd_rw");
      else if (r < 5) access(1, 0, sz, 1'($urandom), BASE + off, $urandom, "rnd_ld");
      else            access(0, 1, sz, 1'($urandom), BASE + off, $urandom, "rnd_st");
    end

    sel = 4;
    access(0, 1, SIZE_WORD, 0, BASE + 32'h100, 32'h0BAD_CAFE, "l4_old");
    access(1, 0, SIZE_WORD, 0, BASE + 32'h100, 32'h0, "l4_ld");
    reset_abort(2, BASE + 32'h100, 32'h1234_5678, "abort_c2");
    access(1, 0, SIZE_WORD, 0, BASE + 32'h100, 32'h0, "abort_c2_ld");
    chk("abort_c2.value", o_data, 32'h0BAD_CAFE);
    reset_abort(3, BASE + 32'h100, 32'hCAFE_F00D, "abort_c3");
    access(1, 0, SIZE_WORD, 0, BASE + 32'h100, 32'h0, "abort_c3_ld");
    chk("abort_c3.value", o_data, 32'h0BAD_CAFE);
    access(1, 0, SIZE_HALF, 1, BASE + 32'h102, 32'h0, "l4_half_u");

    sel = 2;
    for (int b = 0; b < 16; b++) branch_chk(b[0], b[1], b[2], b[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage unit for the pipelined MIPS core, successor to the single-cycle MEM stage. Sits between EX/MEM and MEM/WB. It adds byte/halfword/word loads and stores with sign or zero extension, a configurable multi-cycle memory latency with a pipeline stall handshake, and alignment/range fault detection. Branch/jump next-PC selection is carried over.

## Interface
- NBits, 32: datapath width. Must be 32.
- MEMORY_DEPTH, 512: data memory depth in 32-bit words.
- BASE_ADDRESS, 32'h1001_0000: subtracted from ALUResult to form the memory byte address.
- MEM_LATENCY, 2: access cycles, range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- MemSize  in  2  access size: 00 byte, 01 half, 10 word; 11 is a fault.
- MemUnsigned  in  1  1 = zero-extend loads; 0 = sign-extend loads.
- Zero, BranchEquals, BranchNotEquals, JumpControl  in  1 each  branch/jump controls from EX.
- ALUResult, WriteData, PC_4, BranchAddress, JumpAddress  in  NBits each  EX/MEM operands.
- BranchControl  out  1  PC redirect (jump or taken branch).
- NewPC  out  NBits  next PC.
- DataAddress  out  NBits  ALUResult − BASE_ADDRESS.
- MemoryData  out  NBits  extended load result, registered.
- MemoryDataValid  out  1  one-cycle pulse when a load or store completes.
- Stall  out  1  freeze upstream pipeline.
- MemFault  out  1  one-cycle pulse on a rejected access.

## Operation
- Branch path is combinational and independent of the FSM.
  - Taken = (BranchEquals & Zero) | (BranchNotEquals & ~Zero).
  - NewPC = JumpControl ? JumpAddress : (Taken ? BranchAddress : PC_4). Jump wins on simultaneous assertion.
  - BranchControl = JumpControl | Taken.
- Word index = DataAddress[NBits-1:2]. Byte lane = DataAddress[1:0].
- Fault conditions, evaluated in IDLE:
  - MemRead & MemWrite both asserted.
  - MemSize = 11.
  - Halfword access with DataAddress[0] = 1.
  - Word access with DataAddress[1:0] ≠ 0.
  - Word index ≥ MEMORY_DEPTH.
- On a fault: MemFault pulses for 1 cycle, no memory access occurs, Stall stays 0, and the FSM stays in IDLE.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE → ACCESS on a valid request (MemRead or MemWrite, no fault). The latency counter loads MEM_LATENCY−1.
  - ACCESS decrements the counter. At 0 it commits the access and moves to DONE.
  - DONE → IDLE unconditionally. A request is never accepted in DONE.
- Stores write only the enabled byte lanes:
  - byte: lane = addr[1:0], data = WriteData[7:0].
  - half: lanes {addr[1],0} and {addr[1],1}, data = WriteData[15:0].
  - word: all four lanes.
- Loads select the addressed byte or half and extend it per MemUnsigned. The result is registered into MemoryData on the commit edge.
- MemoryData holds its value until the next load commits. Stores do not change it.

## Timing
- Cycle 0: request seen in IDLE. Stall = 1 combinationally in the same cycle.
- Stall remains 1 through cycle MEM_LATENCY−1.
- Commit happens on the rising edge ending cycle MEM_LATENCY−1. With MEM_LATENCY = 1 this is the edge ending cycle 0.
- Cycle MEM_LATENCY (DONE): Stall = 0, MemoryDataValid = 1, MemoryData is valid. The pipeline advances at the end of this cycle.
- Back-to-back accesses occur every MEM_LATENCY+1 cycles.
- Upstream must hold all inputs stable while Stall = 1. The unit does not latch request operands beyond the address and data needed for the commit.
- Reset values: FSM IDLE, counter 0, MemoryData 0, MemoryDataValid 0, MemFault 0, Stall 0.
- Memory contents are not reset.
- Reset asserted during ACCESS before the commit edge aborts the access: no write lands and the state returns to IDLE next cycle. Reset on the commit edge itself also suppresses the write.

## Structure
- Shared package `mem_pkg`:
  - Size encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - FSM state typedef.
  - Default BASE_ADDRESS.
- One sub-module: `byte_lane_ram`.
  - MEMORY_DEPTH × 32 array with a 4-bit byte write enable.
  - Synchronous write and synchronous read on an enable.
  - FSM, alignment logic, extension logic and branch logic stay in mem_access_unit.

## Test plan
- Word round trip, MEM_LATENCY = 2:
  - Store 0xDEAD_BEEF to ALUResult 0x1001_0008. Stall is high for 2 cycles, then MemoryDataValid pulses.
  - Load from the same address → MemoryData = 0xDEAD_BEEF in cycle 2.
- Byte and half extension:
  - After the word store above, byte load at 0x1001_000B with MemUnsigned = 0 → 0xFFFF_FFDE.
  - Same load with MemUnsigned = 1 → 0x0000_00DE.
  - Half load at 0x1001_0008, signed → 0xFFFF_BEEF.
- Partial store: byte store of 0x55 at 0x1001_0009, then word load at 0x1001_0008 → 0xDEAD_55EF.
- Faults, each giving MemFault = 1 for one cycle, Stall = 0, memory unchanged:
  - Word access at 0x1001_0002.
  - Half access at 0x1001_0001.
  - Word index 512 with MEMORY_DEPTH = 512.
  - MemRead = MemWrite = 1.
- Reset mid-access:
  - Store 0x1234_5678 with MEM_LATENCY = 4, reset asserted in cycle 2.
  - Expect outputs at reset values next cycle.
  - A subsequent load of that address returns the old value.
- Branch/jump:
  - Zero = 1, BranchEquals = 1 → NewPC = BranchAddress, BranchControl = 1.
  - Adding JumpControl = 1 → NewPC = JumpAddress.
  - Zero = 1, BranchNotEquals = 1 → NewPC = PC_4, BranchControl = 0.
